// File: rtl/verify_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : verify_pkg
//  Description : Shared constants, target byte table and FSM encoding for verify.
//  Revision    : 1.0 - initial release
// ============================================================================
package verify_pkg;

    localparam int          TARGET_LEN = 5;
    localparam int          IDX_W      = $clog2(TARGET_LEN + 1);
    localparam logic [7:0]  DELIM      = 8'h00;

    // Element 0 is the first byte expected after the opening delimiter: "Apple".
    localparam logic [TARGET_LEN-1:0][7:0] TARGET = {8'h65, 8'h6C, 8'h70, 8'h70, 8'h41};

    typedef logic [IDX_W-1:0] idx_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RECV    = 2'd1,
        WAIT_TX = 2'd2,
        STROBE  = 2'd3
    } state_t;

    function automatic logic [7:0] target_byte(input idx_t i);
        logic [7:0] b;
        b = DELIM;
        for (int k = 0; k < TARGET_LEN; k++) begin
            if (idx_t'(k) == i) b = TARGET[k];
        end
        return b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/verify_tx_timer.sv
`default_nettype none
// ============================================================================
//  Module      : verify_tx_timer
//  Description : Down-counter that paces the verdict report; done while at zero.
//  Revision    : 1.0 - initial release
// ============================================================================
module verify_tx_timer #(
    parameter int TX_DIV = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    output logic done
);

    localparam int             c_W      = $clog2(TX_DIV + 1);
    localparam logic [c_W-1:0] c_RELOAD = c_W'(TX_DIV - 1);

    logic [c_W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (load) begin
            r_count <= c_RELOAD;
        end else if (r_count != '0) begin
            r_count <= r_count - c_W'(1);
        end
    end

    assign done = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/verify.sv
`default_nettype none
// ============================================================================
//  Module      : verify
//  Description : Checks delimiter-framed byte streams against "Apple" and
//                reports a paced, one-cycle-strobed verdict.
//  Revision    : 1.0 - initial release
// ============================================================================
module verify
    import verify_pkg::*;
#(
    parameter int freq         = 50_000_000,
    parameter int UART_TX_baud = 115200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] ascii_char,
    input  logic       char_valid,
    output logic       sequence_valid,
    output logic       output_strobe
);

    localparam int TX_DIV = freq / UART_TX_baud;

    generate
        if (TX_DIV < 1) begin : g_bad_div
            $error("verify: freq / UART_TX_baud must be at least 1");
        end
    endgenerate

    state_t r_state, w_state_nxt;
    idx_t   r_idx, w_idx_nxt;
    logic   r_ok, w_ok_nxt;
    logic   r_result, w_result_nxt;
    logic   r_seq_valid, w_seq_valid_nxt;
    logic   w_load, w_done, w_strobe, w_is_delim;

    assign w_is_delim = (ascii_char == DELIM);

    verify_tx_timer #(
        .TX_DIV (TX_DIV)
    ) u_tx_timer (
        .clk  (clk),
        .rst  (rst),
        .load (w_load),
        .done (w_done)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_idx       <= '0;
            r_ok        <= 1'b1;
            r_result    <= 1'b0;
            r_seq_valid <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_idx       <= w_idx_nxt;
            r_ok        <= w_ok_nxt;
            r_result    <= w_result_nxt;
            r_seq_valid <= w_seq_valid_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_idx_nxt       = r_idx;
        w_ok_nxt        = r_ok;
        w_result_nxt    = r_result;
        w_seq_valid_nxt = r_seq_valid;
        w_load          = 1'b0;
        w_strobe        = 1'b0;

        case (r_state)
            IDLE: begin
                if (char_valid && w_is_delim) begin
                    w_idx_nxt   = '0;
                    w_ok_nxt    = 1'b1;
                    w_state_nxt = RECV;
                end
            end

            RECV: begin
                if (char_valid) begin
                    if (!w_is_delim) begin
                        // idx stops at TARGET_LEN; any extra byte just clears ok.
                        if ((r_idx < idx_t'(TARGET_LEN)) && (ascii_char == target_byte(r_idx))) begin
                            w_idx_nxt = r_idx + idx_t'(1);
                        end else begin
                            w_ok_nxt = 1'b0;
                        end
                    end else if (!((r_idx == '0) && r_ok)) begin
                        // A back-to-back delimiter pair is an empty frame and just restarts.
                        w_result_nxt = r_ok && (r_idx == idx_t'(TARGET_LEN));
                        w_load       = 1'b1;
                        w_state_nxt  = WAIT_TX;
                    end
                end
            end

            WAIT_TX: begin
                if (w_done) begin
                    w_seq_valid_nxt = r_result;
                    w_state_nxt     = STROBE;
                end
            end

            STROBE: begin
                w_strobe    = 1'b1;
                w_state_nxt = IDLE;
            end

            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign output_strobe  = w_strobe;
    assign sequence_valid = r_seq_valid;

endmodule
`default_nettype wire

// File: tb/tb_verify.sv
`default_nettype none
// ============================================================================
//  Module      : tb_verify
//  Description : Table-driven frame vectors with a strobe scoreboard for verify.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_verify;

    logic       clk;
    logic       rst;
    logic [7:0] ascii_char;
    logic       char_valid;
    logic       sequence_valid;
    logic       output_strobe;

    verify #(
        .freq         (200),
        .UART_TX_baud (20)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .ascii_char     (ascii_char),
        .char_valid     (char_valid),
        .sequence_valid (sequence_valid),
        .output_strobe  (output_strobe)
    );

    localparam int c_TX_DIV = 10;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int applied    = 0;
    int miscompares = 0;
    bit mon_en     = 1'b0;
    bit hv         = 1'b0;

    typedef struct {
        int t;
        bit v;
    } exp_t;
    exp_t sbq[$];

    // '~' stands for the 0x00 delimiter.
    typedef struct {
        string s;
        bit    exp_strobe;
        bit    exp_valid;
    } vec_t;
    vec_t vecs[13];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] req);
        applied++;
        if (got !== req) begin
            miscompares++;
            $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, got, req, cyc);
        end
    endtask

    task automatic step(input int n);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (mon_en && output_strobe !== 1'b0) begin
                if (sbq.size() == 0) begin
                    applied++;
                    miscompares++;
                    $display("FAIL unexpected_strobe: got strobe=%b seq_valid=%b, required no strobe (cycle %0d)",
                             output_strobe, sequence_valid, cyc);
                end else begin
                    e = sbq.pop_front();
                    chk("strobe_cycle", cyc, e.t);
                    chk("strobe_value", {31'b0, sequence_valid}, {31'b0, e.v});
                end
            end
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input bit push, input bit val);
        ascii_char = b;
        char_valid = 1'b1;
        step(1);
        char_valid = 1'b0;
        ascii_char = 8'($urandom);
        if (push) sbq.push_back('{t: cyc + c_TX_DIV, v: val});
        step(9);
    endtask

    task automatic send_str(input string s, input bit push_last, input bit val);
        logic [7:0] b;
        for (int k = 0; k < s.len(); k++) begin
            b = s[k];
            if (b == 8'h7E) b = 8'h00;
            send_byte(b, push_last && (k == s.len() - 1), val);
        end
    endtask

    task automatic end_of_frame(input string name, input bit exp_val);
        step(20);
        chk({name, "_pending"}, sbq.size(), 0);
        sbq.delete();
        chk({name, "_seq_valid"}, {31'b0, sequence_valid}, {31'b0, exp_val});
    endtask

    initial begin
        rst        = 1'b1;
        char_valid = 1'b0;
        ascii_char = 8'h00;

        vecs[0]  = '{s: "~Apple~",   exp_strobe: 1'b1, exp_valid: 1'b1};
        vecs[1]  = '{s: "~Pplle~",   exp_strobe: 1'b1, exp_valid: 1'b0};
        vecs[2]  = '{s: "~Appl~",    exp_strobe: 1'b1, exp_valid: 1'b0};
        vecs[3]  = '{s: "~Applee~",  exp_strobe: 1'b1, exp_valid: 1'b0};
        vecs[4]  = '{s: "~Apple~",   exp_strobe: 1'b1, exp_valid: 1'b1};
        vecs[5]  = '{s: "Apple~~",   exp_strobe: 1'b0, exp_valid: 1'b0};
        vecs[6]  = '{s: "~apple~",   exp_strobe: 1'b1, exp_valid: 1'b0};
        vecs[7]  = '{s: "~Apple~",   exp_strobe: 1'b1, exp_valid: 1'b1};
        vecs[8]  = '{s: "~Applf~",   exp_strobe: 1'b1, exp_valid: 1'b0};
        vecs[9]  = '{s: "~~Apple~",  exp_strobe: 1'b1, exp_valid: 1'b1};
        vecs[10] = '{s: "~~~",       exp_strobe: 1'b0, exp_valid: 1'b0};
        vecs[11] = '{s: "~Xpple~",   exp_strobe: 1'b1, exp_valid: 1'b0};
        vecs[12] = '{s: "~Apple~",   exp_strobe: 1'b1, exp_valid: 1'b1};

        step(100);
        chk("reset_seq_valid", {31'b0, sequence_valid}, 0);
        chk("reset_strobe", {31'b0, output_strobe}, 0);
        rst    = 1'b0;
        mon_en = 1'b1;
        step(5);

        for (int i = 0; i < 13; i++) begin
            send_str(vecs[i].s, vecs[i].exp_strobe, vecs[i].exp_valid);
            if (vecs[i].exp_strobe) hv = vecs[i].exp_valid;
            end_of_frame($sformatf("vec%0d", i), hv);
        end

        // Reset in the middle of a frame: partial frame is dropped.
        send_str("~App", 1'b0, 1'b0);
        rst = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step(1);
            chk("midframe_rst_seq_valid", {31'b0, sequence_valid}, 0);
            chk("midframe_rst_strobe", {31'b0, output_strobe}, 0);
        end
        rst = 1'b0;
        step(5);
        send_str("~Apple~", 1'b1, 1'b1);
        end_of_frame("after_midframe_rst", 1'b1);

        // Reset while the verdict is waiting to be reported.
        send_str("~Apple", 1'b0, 1'b0);
        ascii_char = 8'h00;
        char_valid = 1'b1;
        step(1);
        char_valid = 1'b0;
        step(4);
        rst = 1'b1;
        step(2);
        chk("waittx_rst_seq_valid", {31'b0, sequence_valid}, 0);
        rst = 1'b0;
        step(30);
        chk("waittx_rst_pending", sbq.size(), 0);
        chk("waittx_rst_hold", {31'b0, sequence_valid}, 0);

        send_str("~Apple~", 1'b1, 1'b1);
        end_of_frame("after_waittx_rst", 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
